obi_sram_responder: RTL and testbench

- Memory-side responder for the core's req/gnt/rvalid instruction and data memory interfaces. It produces the `gnt` and `rvalid` signals that the pipeline hazard logic consumes.
- Backed by a word-addressed single-port array, with configurable response latency, an outstanding-request limit and deterministic grant-stall injection.
- Instantiated once for imem and once for dmem in the core-level test harness and the FPGA top.

---
 rtl/obi_sram_responder.sv | 153 +++++++++++++++
 tb/tb_obi_sram_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_responder.sv
// Purpose: req/gnt/rvalid memory responder backed by a word-addressed single-port array.
// Latency: response LATENCY cycles after accept; gnt_o is combinational from req_i.
// Backpressure: gnt_o withheld at the outstanding limit or on injected stall cycles; responses never stall.
module obi_sram_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_PERIOD    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-2:0] MEM_LIMIT = (ADDR_WIDTH-1)'(MEM_WORDS);
  localparam logic [2:0] CNT_MAX = 3'(MAX_OUTSTANDING);
  localparam logic [31:0] STALL_LAST = (STALL_PERIOD > 0) ? 32'(STALL_PERIOD - 1) : 32'd0;
  localparam bit PARAMS_OK = (DATA_WIDTH == 32) &&
                             (MEM_WORDS > 0) && ((MEM_WORDS & (MEM_WORDS - 1)) == 0) &&
                             (LATENCY >= 1) && (LATENCY <= 4) &&
                             (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= 4) &&
                             (STALL_PERIOD >= 0) && (IDX_W <= ADDR_WIDTH - 2);

  // One response slot travelling down the latency pipe.
  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  rsp_t        pipe_q [LATENCY];
  rsp_t        pipe_d [LATENCY];
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic                  stall_now;
  logic [2:0]            out_eff;
  logic                  has_room;
  logic                  accept;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_word;

  // Address decode and error classification for the request currently offered.
  always_comb begin
    word_idx     = addr_i[ADDR_WIDTH-1:2];
    mem_idx      = word_idx[IDX_W-1:0];
    misaligned   = |addr_i[1:0];
    out_of_range = ({1'b0, word_idx} >= MEM_LIMIT);
    acc_err      = misaligned | out_of_range;
    rd_word      = mem_q[mem_idx];
  end

  // Grant: a response retiring this cycle frees its slot immediately, so
  // back-to-back traffic sustains one request per cycle when the limit allows.
  always_comb begin
    stall_now = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_LAST);
    out_eff   = out_cnt_q - 3'(rvalid_o);
    has_room  = (out_eff < CNT_MAX);
    gnt_o     = rst_ni & req_i & has_room & ~stall_now;
    accept    = req_i & gnt_o;
  end

  // Response outputs are forced quiet while reset is held.
  always_comb begin
    rvalid_o = rst_ni & pipe_q[LATENCY-1].vld;
    err_o    = rvalid_o & pipe_q[LATENCY-1].err;
    rdata_o  = rvalid_o ? pipe_q[LATENCY-1].dat : '0;
  end

  // Next state for the response pipe: capture at accept, shift every cycle.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      pipe_d[i] = '0;
    end
    pipe_d[0].vld = accept;
    pipe_d[0].err = accept & acc_err;
    pipe_d[0].dat = (accept && !we_i && !acc_err) ? rd_word : '0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Next state for the outstanding counter and the free-running stall counter.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({accept, rvalid_o})
      2'b10:   out_cnt_d = out_cnt_q + 3'd1;
      2'b01:   out_cnt_d = out_cnt_q - 3'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (STALL_PERIOD != 0) begin
      stall_cnt_d = (stall_cnt_q == STALL_LAST) ? 32'd0 : stall_cnt_q + 32'd1;
    end
  end

  // Control state with synchronous active-low reset; in-flight responses are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      out_cnt_q   <= out_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Array write with per-lane byte enables; errored writes leave the array alone.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  a_params: assert property (@(posedge clk_i) PARAMS_OK);

  a_rvalid_src: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> $past(accept, LATENCY));

  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_cnt_q <= CNT_MAX);

  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> (out_cnt_q != 3'd0));

endmodule

// File: tb/tb_obi_sram_responder.sv
module tb_obi_sram_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req    [4];
  logic        we     [4];
  logic [3:0]  be     [4];
  logic [31:0] addr   [4];
  logic [31:0] wdata  [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    int          dut;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } sb_t;

  sb_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  obi_sram_responder #(.LATENCY(1), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  obi_sram_responder #(.LATENCY(4), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  obi_sram_responder #(.LATENCY(1), .MAX_OUTSTANDING(2), .STALL_PERIOD(4)) u_stall (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  obi_sram_responder #(.LATENCY(3), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[3]), .we_i(we[3]), .be_i(be[3]),
    .addr_i(addr[3]), .wdata_i(wdata[3]), .gnt_o(gnt[3]), .rvalid_o(rvalid[3]),
    .rdata_o(rdata[3]), .err_o(err[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      1:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  // Response monitor: every rvalid must match the oldest expected entry.
  always @(negedge clk) begin
    sb_t e;
    for (int d = 0; d < 4; d++) begin
      if (rvalid[d]) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 32'(rvalid[d]), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_dut", 32'(d), 32'(e.dut));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("rsp_err", 32'(err[d]), 32'(e.err));
          chk("rsp_rdata", rdata[d], e.rdata);
        end
      end else begin
        chk("idle_rdata", rdata[d], 32'd0);
        chk("idle_err", 32'(err[d]), 32'd0);
      end
    end
  end

  // Called #1 after a posedge; holds reset across two posedges with requests high.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) req[d] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        chk("rst_gnt", 32'(gnt[d]), 32'd0);
        chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
        chk("rst_rdata", rdata[d], 32'd0);
        chk("rst_err", 32'(err[d]), 32'd0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 4; d++) req[d] = 1'b0;
    rst_n = 1'b1;
  endtask

  // One request; expected response is queued at the cycle the grant is seen.
  task automatic xfer(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                      output int waited);
    waited = 0;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    while (!gnt[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!gnt[d]) chk("gnt_timeout", 32'(gnt[d]), 32'd1);
    else sbq.push_back('{dut: d, cyc: cyc + lat_of(d), err: e_err, rdata: e_rd});
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0]  exp_lim;
    logic [11:0] exp_stl;
    exp_lim = 10'b1100110011;
    exp_stl = 12'h777;
    for (int d = 0; d < 4; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
    end
    @(posedge clk); #1;
    do_reset();

    // Latency 1: preload, single read, byte-enable write, errors.
    xfer(0, 1'b1, 4'hF, 32'h14, 32'hDEADBEEF, 1'b0, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF, n);
    chk("read_gnt_wait", 32'(n), 32'd0);
    xfer(0, 1'b1, 4'hF, 32'h8, 32'h11223344, 1'b0, 32'h0, n);
    xfer(0, 1'b1, 4'b0101, 32'h8, 32'hAABBCCDD, 1'b0, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, 32'h11BB33DD, n);
    chk("b2b_gnt_wait", 32'(n), 32'd0);
    xfer(0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'h2, 32'h0, 1'b1, 32'h0, n);
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'h1004, 32'h0, 1'b1, 32'h0, n);
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, n);
    xfer(0, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0, 32'hDEADBEEF, n);
    drain();

    // Latency 4, two outstanding: grant pattern under a held request.
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h40; wdata[1] = 32'h5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("limit_gnt", 32'(gnt[1]), 32'(exp_lim[i]));
      if (gnt[1]) sbq.push_back('{dut: 1, cyc: cyc + 4, err: 1'b0, rdata: 32'h0});
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    drain();

    // Stall injection every fourth cycle from reset release.
    do_reset();
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h10; wdata[2] = 32'h77;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("stall_gnt", 32'(gnt[2]), 32'(exp_stl[i]));
      if (gnt[2]) sbq.push_back('{dut: 2, cyc: cyc + 1, err: 1'b0, rdata: 32'h0});
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    drain();

    // Latency 3: two reads in flight are discarded by a reset.
    req[3] = 1'b1; we[3] = 1'b0; be[3] = 4'hF; addr[3] = 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("inflight_gnt", 32'(gnt[3]), 32'd1);
      @(posedge clk); #1;
    end
    req[3] = 1'b0;
    @(posedge clk); #1;
    do_reset();
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h20; wdata[3] = 32'h1234;
    @(negedge clk);
    chk("post_reset_gnt", 32'(gnt[3]), 32'd1);
    if (gnt[3]) sbq.push_back('{dut: 3, cyc: cyc + 3, err: 1'b0, rdata: 32'h0});
    @(posedge clk); #1;
    req[3] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
